// File: rtl/rr_mux_arbiter_if.sv
// Handshake bundle between N upstream channels, the arbiter, and one downstream sink.
// The master side drives requests and out_ready; the slave side is the arbiter itself.
interface rr_mux_arbiter_if #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = 2
);
   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [NUM_IN-1:0]       in_valid;
   logic [NUM_IN-1:0]       in_ready;
   logic                    mode;
   logic [SEL_W-1:0]        sel;
   logic [WIDTH-1:0]        out_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [SEL_W-1:0]        out_grant;

   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_valid, out_grant
   );

   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_valid, out_grant
   );
endinterface

// File: rtl/rr_mux_arbiter.sv
// N-to-1 multiplexing arbiter with fixed-select or round-robin choice and a
// one-entry registered output stage that sustains one word per cycle.
module rr_mux_arbiter #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   rr_mux_arbiter_if.slave   bus
);

   localparam logic [SEL_W:0]   NumInW  = (SEL_W+1)'(NUM_IN);
   localparam logic [SEL_W-1:0] LastIdx = SEL_W'(NUM_IN - 1);

   logic [WIDTH-1:0]  outData_q, outData_d;
   logic [SEL_W-1:0]  outGrant_q, outGrant_d;
   logic              outValid_q, outValid_d;
   logic [SEL_W-1:0]  rrPtr_q, rrPtr_d;

   logic              load;
   logic              hasChoice;
   logic              xfer;
   logic [SEL_W-1:0]  chosen;
   logic [SEL_W:0]    rrResult;
   logic [NUM_IN-1:0] readyVec;
   logic [WIDTH-1:0]  chanData [NUM_IN];

   for (genvar g = 0; g < NUM_IN; g++) begin : gUnpack
      assign chanData[g] = bus.in_data[g*WIDTH +: WIDTH];
   end

   // Scan channels cyclically from ptr; returns {found, index} of the first requester.
   function automatic logic [SEL_W:0] rrPick(input logic [SEL_W-1:0] ptr,
                                             input logic [NUM_IN-1:0] valid);
      logic [SEL_W:0]   sum;
      logic [SEL_W-1:0] cand;
      logic             found;
      logic [SEL_W-1:0] pick;
      found = 1'b0;
      pick  = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         sum = {1'b0, ptr} + (SEL_W+1)'(k);
         if (sum >= NumInW) begin
            sum = sum - NumInW;
         end
         cand = sum[SEL_W-1:0];
         if (!found && valid[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
      return {found, pick};
   endfunction

   assign load     = !outValid_q | bus.out_ready;
   assign rrResult = rrPick(rrPtr_q, bus.in_valid);

   // A channel is only ever chosen if it is requesting, so ready implies a transfer.
   always_comb begin
      hasChoice = 1'b0;
      chosen    = '0;
      if (!bus.mode) begin
         if ({1'b0, bus.sel} < NumInW) begin
            if (bus.in_valid[bus.sel]) begin
               hasChoice = 1'b1;
               chosen    = bus.sel;
            end
         end
      end else begin
         hasChoice = rrResult[SEL_W];
         chosen    = rrResult[SEL_W-1:0];
      end
   end

   assign xfer = hasChoice & load & rst_n;

   always_comb begin
      readyVec = '0;
      if (xfer) begin
         readyVec[chosen] = 1'b1;
      end
   end

   // Empty slot or a draining word means the register reloads (or empties) this edge.
   always_comb begin
      outData_d  = outData_q;
      outGrant_d = outGrant_q;
      outValid_d = outValid_q;
      rrPtr_d    = rrPtr_q;
      if (load) begin
         outValid_d = xfer;
         if (xfer) begin
            outData_d  = chanData[chosen];
            outGrant_d = chosen;
            if (bus.mode) begin
               rrPtr_d = (chosen == LastIdx) ? '0 : chosen + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outData_q  <= '0;
         outGrant_q <= '0;
         outValid_q <= 1'b0;
         rrPtr_q    <= '0;
      end else begin
         outData_q  <= outData_d;
         outGrant_q <= outGrant_d;
         outValid_q <= outValid_d;
         rrPtr_q    <= rrPtr_d;
      end
   end

   assign bus.in_ready  = readyVec;
   assign bus.out_data  = outData_q;
   assign bus.out_valid = outValid_q;
   assign bus.out_grant = outGrant_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench: a 4-channel and a 3-channel arbiter, expected words queued
// when a transfer is provoked and compared when they appear in the output register.
module tb_rr_mux_arbiter;

   typedef struct packed {
      logic [1:0] grant;
      logic [7:0] data;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checkCount;
   int   passCount;
   exp_t expQ[$];
   exp_t e;
   logic [7:0] chanVal4 [4];
   logic [7:0] chanVal3 [3];

   rr_mux_arbiter_if #(.WIDTH(8), .NUM_IN(4), .SEL_W(2)) bus4 ();
   rr_mux_arbiter_if #(.WIDTH(8), .NUM_IN(3), .SEL_W(2)) bus3 ();

   rr_mux_arbiter #(.WIDTH(8), .NUM_IN(4), .SEL_W(2)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4)
   );

   rr_mux_arbiter #(.WIDTH(8), .NUM_IN(3), .SEL_W(2)) dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n          = 1'b0;
      bus4.in_valid  = 4'hF;
      bus4.mode      = 1'b1;
      bus4.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkCount++;
      if (bus4.out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", bus4.out_valid);
      else passCount++;
      checkCount++;
      if (bus4.out_data !== 8'h00) $display("[TB] FAIL reset_data: got %h expected 00", bus4.out_data);
      else passCount++;
      checkCount++;
      if (bus4.out_grant !== 2'd0) $display("[TB] FAIL reset_grant: got %0d expected 0", bus4.out_grant);
      else passCount++;
      checkCount++;
      if (bus4.in_ready !== 4'b0000) $display("[TB] FAIL reset_in_ready: got %b expected 0000", bus4.in_ready);
      else passCount++;
      bus4.in_valid = 4'h0;
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_fixed_select();
      bus4.mode      = 1'b0;
      bus4.in_valid  = 4'hF;
      bus4.out_ready = 1'b1;
      for (int s = 0; s < 4; s++) begin
         bus4.sel = 2'(s);
         expQ.push_back('{grant: 2'(s), data: chanVal4[s]});
         #1;
         checkCount++;
         if (bus4.in_ready !== (4'b0001 << s)) $display("[TB] FAIL fixed_in_ready: got %b expected %b", bus4.in_ready, 4'b0001 << s);
         else passCount++;
         @(posedge clk);
         @(negedge clk);
         e = (expQ.size() > 0) ? expQ.pop_front() : exp_t'('1);
         checkCount++;
         if (bus4.out_valid !== 1'b1 || bus4.out_grant !== e.grant || bus4.out_data !== e.data)
            $display("[TB] FAIL fixed_word: got v=%b g=%0d d=%h expected v=1 g=%0d d=%h",
                     bus4.out_valid, bus4.out_grant, bus4.out_data, e.grant, e.data);
         else passCount++;
      end
      bus4.in_valid = 4'h0;
      @(posedge clk);
      @(negedge clk);
      checkCount++;
      if (bus4.out_valid !== 1'b0 || bus4.out_data !== 8'h44 || bus4.out_grant !== 2'd3)
         $display("[TB] FAIL idle_drain: got v=%b g=%0d d=%h expected v=0 g=3 d=44",
                  bus4.out_valid, bus4.out_grant, bus4.out_data);
      else passCount++;
   endtask

   task automatic test_round_robin();
      bus4.mode      = 1'b1;
      bus4.in_valid  = 4'hF;
      bus4.out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         expQ.push_back('{grant: 2'(c % 4), data: chanVal4[c % 4]});
         #1;
         checkCount++;
         if (bus4.in_ready !== (4'b0001 << (c % 4))) $display("[TB] FAIL rr_in_ready: got %b expected %b", bus4.in_ready, 4'b0001 << (c % 4));
         else passCount++;
         @(posedge clk);
         @(negedge clk);
         e = (expQ.size() > 0) ? expQ.pop_front() : exp_t'('1);
         checkCount++;
         if (bus4.out_valid !== 1'b1 || bus4.out_grant !== e.grant || bus4.out_data !== e.data)
            $display("[TB] FAIL rr_word: got v=%b g=%0d d=%h expected v=1 g=%0d d=%h",
                     bus4.out_valid, bus4.out_grant, bus4.out_data, e.grant, e.data);
         else passCount++;
      end
      bus4.in_valid = 4'h0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_sparse();
      logic [1:0] g;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n          = 1'b1;
      bus4.mode      = 1'b1;
      bus4.in_valid  = 4'b1010;
      bus4.out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         g = (c % 2 == 0) ? 2'd1 : 2'd3;
         expQ.push_back('{grant: g, data: chanVal4[g]});
         #1;
         checkCount++;
         if (bus4.in_ready !== (4'b0001 << g)) $display("[TB] FAIL sparse_in_ready: got %b expected %b", bus4.in_ready, 4'b0001 << g);
         else passCount++;
         @(posedge clk);
         @(negedge clk);
         e = (expQ.size() > 0) ? expQ.pop_front() : exp_t'('1);
         checkCount++;
         if (bus4.out_valid !== 1'b1 || bus4.out_grant !== e.grant || bus4.out_data !== e.data)
            $display("[TB] FAIL sparse_word: got v=%b g=%0d d=%h expected v=1 g=%0d d=%h",
                     bus4.out_valid, bus4.out_grant, bus4.out_data, e.grant, e.data);
         else passCount++;
      end
      bus4.in_valid = 4'h0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      bus4.mode      = 1'b0;
      bus4.sel       = 2'd2;
      bus4.in_valid  = 4'hF;
      bus4.out_ready = 1'b1;
      expQ.push_back('{grant: 2'd2, data: chanVal4[2]});
      @(posedge clk);
      @(negedge clk);
      e = (expQ.size() > 0) ? expQ.pop_front() : exp_t'('1);
      checkCount++;
      if (bus4.out_valid !== 1'b1 || bus4.out_grant !== e.grant || bus4.out_data !== e.data)
         $display("[TB] FAIL bp_first_word: got v=%b g=%0d d=%h expected v=1 g=%0d d=%h",
                  bus4.out_valid, bus4.out_grant, bus4.out_data, e.grant, e.data);
      else passCount++;
      bus4.out_ready = 1'b0;
      bus4.sel       = 2'd1;
      for (int c = 0; c < 3; c++) begin
         #1;
         checkCount++;
         if (bus4.in_ready !== 4'b0000) $display("[TB] FAIL bp_in_ready: got %b expected 0000", bus4.in_ready);
         else passCount++;
         @(posedge clk);
         @(negedge clk);
         checkCount++;
         if (bus4.out_valid !== 1'b1 || bus4.out_grant !== 2'd2 || bus4.out_data !== 8'h33)
            $display("[TB] FAIL bp_hold: got v=%b g=%0d d=%h expected v=1 g=2 d=33",
                     bus4.out_valid, bus4.out_grant, bus4.out_data);
         else passCount++;
      end
      bus4.out_ready = 1'b1;
      expQ.push_back('{grant: 2'd1, data: chanVal4[1]});
      #1;
      checkCount++;
      if (bus4.in_ready !== 4'b0010) $display("[TB] FAIL bp_release_ready: got %b expected 0010", bus4.in_ready);
      else passCount++;
      @(posedge clk);
      @(negedge clk);
      e = (expQ.size() > 0) ? expQ.pop_front() : exp_t'('1);
      checkCount++;
      if (bus4.out_valid !== 1'b1 || bus4.out_grant !== e.grant || bus4.out_data !== e.data)
         $display("[TB] FAIL bp_reload: got v=%b g=%0d d=%h expected v=1 g=%0d d=%h",
                  bus4.out_valid, bus4.out_grant, bus4.out_data, e.grant, e.data);
      else passCount++;
      bus4.in_valid = 4'h0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_nonpow2();
      bus3.mode      = 1'b0;
      bus3.sel       = 2'd1;
      bus3.in_valid  = 3'b111;
      bus3.out_ready = 1'b1;
      expQ.push_back('{grant: 2'd1, data: chanVal3[1]});
      #1;
      checkCount++;
      if (bus3.in_ready !== 3'b010) $display("[TB] FAIL n3_sel_ready: got %b expected 010", bus3.in_ready);
      else passCount++;
      @(posedge clk);
      @(negedge clk);
      e = (expQ.size() > 0) ? expQ.pop_front() : exp_t'('1);
      checkCount++;
      if (bus3.out_valid !== 1'b1 || bus3.out_grant !== e.grant || bus3.out_data !== e.data)
         $display("[TB] FAIL n3_sel_word: got v=%b g=%0d d=%h expected v=1 g=%0d d=%h",
                  bus3.out_valid, bus3.out_grant, bus3.out_data, e.grant, e.data);
      else passCount++;
      bus3.sel = 2'd3;
      #1;
      checkCount++;
      if (bus3.in_ready !== 3'b000) $display("[TB] FAIL n3_bad_sel_ready: got %b expected 000", bus3.in_ready);
      else passCount++;
      @(posedge clk);
      @(negedge clk);
      checkCount++;
      if (bus3.out_valid !== 1'b0 || bus3.out_data !== 8'hB2)
         $display("[TB] FAIL n3_bad_sel_drain: got v=%b d=%h expected v=0 d=b2", bus3.out_valid, bus3.out_data);
      else passCount++;
      bus3.mode = 1'b1;
      for (int c = 0; c < 4; c++) begin
         expQ.push_back('{grant: 2'(c % 3), data: chanVal3[c % 3]});
         @(posedge clk);
         @(negedge clk);
         e = (expQ.size() > 0) ? expQ.pop_front() : exp_t'('1);
         checkCount++;
         if (bus3.out_valid !== 1'b1 || bus3.out_grant !== e.grant || bus3.out_data !== e.data)
            $display("[TB] FAIL n3_rr_word: got v=%b g=%0d d=%h expected v=1 g=%0d d=%h",
                     bus3.out_valid, bus3.out_grant, bus3.out_data, e.grant, e.data);
         else passCount++;
      end
      bus3.in_valid = 3'b000;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      bus4.mode      = 1'b1;
      bus4.in_valid  = 4'b0010;
      bus4.out_ready = 1'b1;
      expQ.push_back('{grant: 2'd1, data: chanVal4[1]});
      @(posedge clk);
      @(negedge clk);
      e = (expQ.size() > 0) ? expQ.pop_front() : exp_t'('1);
      checkCount++;
      if (bus4.out_valid !== 1'b1 || bus4.out_grant !== e.grant || bus4.out_data !== e.data)
         $display("[TB] FAIL ar_pre_word: got v=%b g=%0d d=%h expected v=1 g=%0d d=%h",
                  bus4.out_valid, bus4.out_grant, bus4.out_data, e.grant, e.data);
      else passCount++;
      bus4.out_ready = 1'b0;
      bus4.in_valid  = 4'hF;
      @(posedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkCount++;
      if (bus4.out_valid !== 1'b0 || bus4.out_data !== 8'h00 || bus4.out_grant !== 2'd0)
         $display("[TB] FAIL ar_immediate: got v=%b g=%0d d=%h expected v=0 g=0 d=00",
                  bus4.out_valid, bus4.out_grant, bus4.out_data);
      else passCount++;
      checkCount++;
      if (bus4.in_ready !== 4'b0000) $display("[TB] FAIL ar_in_ready: got %b expected 0000", bus4.in_ready);
      else passCount++;
      @(posedge clk);
      @(negedge clk);
      rst_n          = 1'b1;
      bus4.out_ready = 1'b1;
      expQ.push_back('{grant: 2'd0, data: chanVal4[0]});
      #1;
      checkCount++;
      if (bus4.in_ready !== 4'b0001) $display("[TB] FAIL ar_first_ready: got %b expected 0001", bus4.in_ready);
      else passCount++;
      @(posedge clk);
      @(negedge clk);
      e = (expQ.size() > 0) ? expQ.pop_front() : exp_t'('1);
      checkCount++;
      if (bus4.out_valid !== 1'b1 || bus4.out_grant !== e.grant || bus4.out_data !== e.data)
         $display("[TB] FAIL ar_first_word: got v=%b g=%0d d=%h expected v=1 g=%0d d=%h",
                  bus4.out_valid, bus4.out_grant, bus4.out_data, e.grant, e.data);
      else passCount++;
      bus4.in_valid = 4'h0;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;
      chanVal4[0] = 8'h11;
      chanVal4[1] = 8'h22;
      chanVal4[2] = 8'h33;
      chanVal4[3] = 8'h44;
      chanVal3[0] = 8'hA1;
      chanVal3[1] = 8'hB2;
      chanVal3[2] = 8'hC3;
      bus4.in_data   = {chanVal4[3], chanVal4[2], chanVal4[1], chanVal4[0]};
      bus4.in_valid  = 4'h0;
      bus4.mode      = 1'b0;
      bus4.sel       = 2'd0;
      bus4.out_ready = 1'b1;
      bus3.in_data   = {chanVal3[2], chanVal3[1], chanVal3[0]};
      bus3.in_valid  = 3'b000;
      bus3.mode      = 1'b0;
      bus3.sel       = 2'd0;
      bus3.out_ready = 1'b1;

      test_reset();
      test_fixed_select();
      test_round_robin();
      test_sparse();
      test_backpressure();
      test_nonpow2();
      test_async_reset();

      checkCount++;
      if (expQ.size() != 0) $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", expQ.size());
      else passCount++;

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
